// File: rtl/band_power_accum.sv
// ---------------------------------------------------------------------------
// band_power_accum
//
// Mean-power estimator for one band of the band-pass IIR filter chain.
// Each valid signed sample is squared and summed over a window of
// 2^WIN_LOG2 samples. The window mean (sum >> WIN_LOG2, truncated) is
// offered to the feature/classifier logic over a valid/ready handshake.
//
// Pipeline: S1 registers the sample, S2 registers its square, S3 adds the
// square into the accumulator. The last sample of a window captured at edge t
// produces power_valid at edge t+3.
//
// Optional feature: define BAND_POWER_PEAK_EN to add peak_out, the maximum
// |sample_in| seen over the window. It is updated alongside power_out.
//
// Ports:
//   clk           system clock, rising edge
//   reset         synchronous, active-high reset
//   enable        1 = accumulate, 0 = abort the current window and idle
//   sample_in     signed filtered sample (DATA_W)
//   sample_valid  sample_in valid this cycle (no backpressure)
//   power_out     unsigned window mean power (2*DATA_W)
//   power_valid   power_out holds an unconsumed result
//   power_ready   consumer takes power_out when power_valid & power_ready
//   overrun       sticky: a result was overwritten before it was accepted
//   overrun_clr   clears overrun (a simultaneous new overrun wins)
//   peak_out      max |sample| over the window (BAND_POWER_PEAK_EN only)
// ---------------------------------------------------------------------------
module band_power_accum #(
    parameter int DATA_W   = 32,
    parameter int WIN_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic signed [DATA_W-1:0]   sample_in,
    input  logic                       sample_valid,
    output logic [2*DATA_W-1:0]        power_out,
    output logic                       power_valid,
    input  logic                       power_ready,
    output logic                       overrun,
    input  logic                       overrun_clr
`ifdef BAND_POWER_PEAK_EN
    ,
    output logic [DATA_W-1:0]          peak_out
`endif
);

    localparam int ACC_W = 2*DATA_W + WIN_LOG2;
    localparam logic [WIN_LOG2-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    state_t                    state;
    logic                      drain_cnt;
    logic [WIN_LOG2-1:0]       count;
    logic [ACC_W-1:0]          acc;

    logic                      s1_valid;
    logic signed [DATA_W-1:0]  s1_data;
    logic                      s2_valid;
    logic [2*DATA_W-1:0]       s2_sq;

    logic signed [2*DATA_W-1:0] square;
    logic [ACC_W-1:0]           add_term;
    logic [2*DATA_W-1:0]        result;

    // The signed square of the most negative sample is 2^(2*DATA_W-2), which
    // still fits the signed product, so reinterpreting it as unsigned is safe.
    assign square   = s1_data * s1_data;
    assign add_term = s2_valid ? {{WIN_LOG2{1'b0}}, s2_sq} : '0;
    assign result   = acc[ACC_W-1:WIN_LOG2];

`ifdef BAND_POWER_PEAK_EN
    logic [DATA_W-1:0] abs_val;
    logic [DATA_W-1:0] s2_abs;
    logic [DATA_W-1:0] peak_acc;
    logic [DATA_W-1:0] peak_term;
    logic [DATA_W-1:0] peak_next;

    // Two's-complement negation read as unsigned maps -2^(DATA_W-1) onto
    // 2^(DATA_W-1), so no extra bit is needed.
    assign abs_val   = s1_data[DATA_W-1] ? (~s1_data + 1'b1) : s1_data;
    assign peak_term = s2_valid ? s2_abs : '0;
    assign peak_next = (peak_term > peak_acc) ? peak_term : peak_acc;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            drain_cnt   <= 1'b0;
            count       <= '0;
            acc         <= '0;
            s1_valid    <= 1'b0;
            s1_data     <= '0;
            s2_valid    <= 1'b0;
            s2_sq       <= '0;
            power_out   <= '0;
            power_valid <= 1'b0;
            overrun     <= 1'b0;
`ifdef BAND_POWER_PEAK_EN
            s2_abs      <= '0;
            peak_acc    <= '0;
            peak_out    <= '0;
`endif
        end else begin
            // Dropping enable flushes samples still travelling through S1/S2.
            s1_valid <= sample_valid & enable;
            s1_data  <= sample_in;
            s2_valid <= s1_valid & enable;
            s2_sq    <= $unsigned(square);
`ifdef BAND_POWER_PEAK_EN
            s2_abs   <= abs_val;
`endif

            // NOTE: defaults first, overrides later in this block; with
            // non-blocking assignments the last one executed wins, which is how
            // a new result beats acceptance and an overrun set beats its clear.
            if (power_valid && power_ready) power_valid <= 1'b0;
            if (overrun_clr) overrun <= 1'b0;

            case (state)
                DRAIN: begin
                    if (!drain_cnt) begin
                        // Final square of the window retires into acc here;
                        // S1 may already hold samples of the next window.
                        drain_cnt <= 1'b1;
                        acc       <= acc + add_term;
`ifdef BAND_POWER_PEAK_EN
                        peak_acc  <= peak_next;
`endif
                        if (enable && s1_valid) count <= count + 1'b1;
                    end else begin
                        power_out   <= result;
                        power_valid <= 1'b1;
                        if (power_valid && !power_ready) overrun <= 1'b1;
`ifdef BAND_POWER_PEAK_EN
                        peak_out    <= peak_acc;
`endif
                        drain_cnt   <= 1'b0;
                        if (enable) begin
                            // Clear and first add of the next window coincide.
                            acc <= add_term;
`ifdef BAND_POWER_PEAK_EN
                            peak_acc <= peak_term;
`endif
                            if (s1_valid) begin
                                count <= count + 1'b1;
                                state <= (count == CNT_MAX) ? DRAIN : ACCUM;
                            end else begin
                                state <= ACCUM;
                            end
                        end else begin
                            acc   <= '0;
                            count <= '0;
`ifdef BAND_POWER_PEAK_EN
                            peak_acc <= '0;
`endif
                            state <= IDLE;
                        end
                    end
                end

                default: begin  // IDLE and ACCUM
                    if (!enable) begin
                        acc   <= '0;
                        count <= '0;
`ifdef BAND_POWER_PEAK_EN
                        peak_acc <= '0;
`endif
                        state <= IDLE;
                    end else begin
                        acc <= acc + add_term;
`ifdef BAND_POWER_PEAK_EN
                        peak_acc <= peak_next;
`endif
                        state <= ACCUM;
                        if (s1_valid) begin
                            // Counter wraps to zero on the last sample, so the
                            // next window starts counting from zero in DRAIN.
                            count <= count + 1'b1;
                            if (count == CNT_MAX) begin
                                state     <= DRAIN;
                                drain_cnt <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_band_power_accum.sv
// ---------------------------------------------------------------------------
// Testbench for band_power_accum with WIN_LOG2=2 (window of 4 samples).
// A transaction-level model (sample lists, result queue with due edges)
// predicts the outputs after every clock edge.
// ---------------------------------------------------------------------------
module tb_band_power_accum;

    localparam int DATA_W   = 32;
    localparam int WIN_LOG2 = 2;
    localparam int WIN      = 1 << WIN_LOG2;
    localparam int LAT      = 3;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     enable = 1'b0;
    logic signed [DATA_W-1:0] sample_in = '0;
    logic                     sample_valid = 1'b0;
    logic [2*DATA_W-1:0]      power_out;
    logic                     power_valid;
    logic                     power_ready = 1'b1;
    logic                     overrun;
    logic                     overrun_clr = 1'b0;
`ifdef BAND_POWER_PEAK_EN
    logic [DATA_W-1:0]        peak_out;
`endif

    band_power_accum #(.DATA_W(DATA_W), .WIN_LOG2(WIN_LOG2)) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .sample_in(sample_in),
        .sample_valid(sample_valid),
        .power_out(power_out),
        .power_valid(power_valid),
        .power_ready(power_ready),
        .overrun(overrun),
        .overrun_clr(overrun_clr)
`ifdef BAND_POWER_PEAK_EN
        ,
        .peak_out(peak_out)
`endif
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    typedef struct {
        int                  due;
        logic [2*DATA_W-1:0] pw;
        logic [DATA_W-1:0]   pk;
    } res_t;

    int                  edge_n = 0;
    int                  win_q[$];
    res_t                due_q[$];
    logic                m_vld = 1'b0;
    logic                m_ov  = 1'b0;
    logic [2*DATA_W-1:0] m_out = '0;
    logic [DATA_W-1:0]   m_pk  = '0;

    always @(posedge clk) begin
        edge_n++;
        if (reset) begin
            win_q.delete();
            due_q.delete();
            m_vld = 1'b0;
            m_ov  = 1'b0;
            m_out = '0;
            m_pk  = '0;
        end else begin
            if (due_q.size() > 0 && due_q[0].due == edge_n) begin
                if (m_vld && !power_ready) m_ov = 1'b1;
                else if (overrun_clr)      m_ov = 1'b0;
                m_out = due_q[0].pw;
                m_pk  = due_q[0].pk;
                m_vld = 1'b1;
                void'(due_q.pop_front());
            end else begin
                if (m_vld && power_ready) m_vld = 1'b0;
                if (overrun_clr) m_ov = 1'b0;
            end
            if (!enable) begin
                win_q.delete();
            end else if (sample_valid) begin
                win_q.push_back(int'(sample_in));
                if (win_q.size() == WIN) begin
                    logic [2*DATA_W+1:0] sum;
                    longint              mag;
                    res_t                r;
                    sum  = '0;
                    r.pk = '0;
                    foreach (win_q[i]) begin
                        mag = (win_q[i] < 0) ? -longint'(win_q[i]) : longint'(win_q[i]);
                        sum = sum + (2*DATA_W+2)'(mag * mag);
                        if (DATA_W'(mag) > r.pk) r.pk = DATA_W'(mag);
                    end
                    r.pw  = (2*DATA_W)'(sum / WIN);
                    r.due = edge_n + LAT;
                    due_q.push_back(r);
                    win_q.delete();
                end
            end
        end
    end

`ifdef BAND_POWER_PEAK_EN
    wire [2*DATA_W+DATA_W+1:0] obs   = {power_valid, overrun, power_out, peak_out};
    wire [2*DATA_W+DATA_W+1:0] exp_v = {m_vld, m_ov, m_out, m_pk};
`else
    wire [2*DATA_W+1:0] obs   = {power_valid, overrun, power_out};
    wire [2*DATA_W+1:0] exp_v = {m_vld, m_ov, m_out};
`endif

    // Drives one cycle of inputs at the falling edge; outputs observed right
    // after this returns reflect the previous rising edge.
    task automatic step(input logic en, input logic v, input int d);
        @(negedge clk);
        enable       = en;
        sample_valid = v;
        sample_in    = d;
    endtask

    // ------------------------------------------------------------------
    // Scenarios
    // ------------------------------------------------------------------
    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1000 + i);
            total++;
            if (obs !== exp_v) $display("FAIL reset_model t=%0t got %h exp %h", $time, obs, exp_v);
            else passed++;
            total++;
            if ({power_valid, overrun, power_out} !== '0)
                $display("FAIL reset_value t=%0t got v=%b ov=%b out=%h exp all zero", $time, power_valid, overrun, power_out);
            else passed++;
        end
        reset = 1'b0;
        step(1'b0, 1'b0, 0);
    endtask

    task automatic test_basic();
        int vals[4] = '{2, -2, 2, -2};
        power_ready = 1'b1;
        foreach (vals[i]) step(1'b1, 1'b1, vals[i]);
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, 0);
            total++;
            if (obs !== exp_v) $display("FAIL basic_model k=%0d got %h exp %h", k, obs, exp_v);
            else passed++;
            if (k == LAT) begin
                total++;
                if (power_valid !== 1'b0) $display("FAIL basic_early got valid=%b exp 0", power_valid);
                else passed++;
            end
            if (k == LAT + 1) begin
                total++;
                if (power_valid !== 1'b1 || power_out !== 64'd4 || overrun !== 1'b0)
                    $display("FAIL basic_result got v=%b out=%0d ov=%b exp v=1 out=4 ov=0", power_valid, power_out, overrun);
                else passed++;
            end
        end
    endtask

    task automatic test_gaps();
        int vals[4] = '{3, 0, 0, 0};
        foreach (vals[i]) begin
            step(1'b1, 1'b1, vals[i]);
            total++;
            if (obs !== exp_v) $display("FAIL gaps_model i=%0d got %h exp %h", i, obs, exp_v);
            else passed++;
            step(1'b1, 1'b0, 32'h7fff_ffff);
            total++;
            if (obs !== exp_v) $display("FAIL gaps_model_gap i=%0d got %h exp %h", i, obs, exp_v);
            else passed++;
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 0);
            total++;
            if (obs !== exp_v) $display("FAIL gaps_tail k=%0d got %h exp %h", k, obs, exp_v);
            else passed++;
        end
        total++;
        if (power_out !== 64'd2) $display("FAIL gaps_result got %0d exp 2", power_out);
        else passed++;
    endtask

    task automatic test_min_sample();
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, 32'h8000_0000);
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 0);
            total++;
            if (obs !== exp_v) $display("FAIL min_model k=%0d got %h exp %h", k, obs, exp_v);
            else passed++;
        end
        total++;
        if (power_out !== 64'h4000_0000_0000_0000) $display("FAIL min_result got %h exp 4000000000000000", power_out);
        else passed++;
`ifdef BAND_POWER_PEAK_EN
        total++;
        if (peak_out !== 32'h8000_0000) $display("FAIL min_peak got %h exp 80000000", peak_out);
        else passed++;
`endif
    endtask

    task automatic test_overrun();
        power_ready = 1'b0;
        for (int i = 0; i < 2*WIN; i++) begin
            step(1'b1, 1'b1, (i < WIN) ? 1 : 4);
            total++;
            if (obs !== exp_v) $display("FAIL ovr_model i=%0d got %h exp %h", i, obs, exp_v);
            else passed++;
        end
        for (int k = 0; k < 5; k++) begin
            step(1'b1, 1'b0, 0);
            total++;
            if (obs !== exp_v) $display("FAIL ovr_tail k=%0d got %h exp %h", k, obs, exp_v);
            else passed++;
        end
        total++;
        if (power_valid !== 1'b1 || power_out !== 64'd16 || overrun !== 1'b1)
            $display("FAIL ovr_state got v=%b out=%0d ov=%b exp v=1 out=16 ov=1", power_valid, power_out, overrun);
        else passed++;
        overrun_clr = 1'b1;
        step(1'b1, 1'b0, 0);
        overrun_clr = 1'b0;
        step(1'b1, 1'b0, 0);
        total++;
        if (overrun !== 1'b0 || power_valid !== 1'b1) $display("FAIL ovr_clear got ov=%b v=%b exp ov=0 v=1", overrun, power_valid);
        else passed++;
        power_ready = 1'b1;
        step(1'b1, 1'b0, 0);
        step(1'b1, 1'b0, 0);
        total++;
        if (power_valid !== 1'b0 || obs !== exp_v) $display("FAIL ovr_accept got %h exp %h (valid must drop)", obs, exp_v);
        else passed++;
    endtask

    task automatic test_abort();
        step(1'b1, 1'b1, 100);
        step(1'b1, 1'b1, 100);
        step(1'b0, 1'b0, 0);
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, 1);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 0);
            total++;
            if (obs !== exp_v) $display("FAIL abort_model k=%0d got %h exp %h", k, obs, exp_v);
            else passed++;
        end
        total++;
        if (power_out !== 64'd1) $display("FAIL abort_result got %0d exp 1", power_out);
        else passed++;
    endtask

    task automatic test_reset_mid();
        power_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 7);
        reset = 1'b1;
        step(1'b1, 1'b0, 0);
        reset = 1'b0;
        step(1'b1, 1'b0, 0);
        total++;
        if (power_valid !== 1'b0 || obs !== exp_v) $display("FAIL rstmid_clear got %h exp %h", obs, exp_v);
        else passed++;
        power_ready = 1'b1;
        for (int i = 0; i < WIN; i++) step(1'b1, 1'b1, 2);
        for (int k = 0; k < 6; k++) begin
            step(1'b1, 1'b0, 0);
            total++;
            if (obs !== exp_v) $display("FAIL rstmid_model k=%0d got %h exp %h", k, obs, exp_v);
            else passed++;
        end
        total++;
        if (power_out !== 64'd4) $display("FAIL rstmid_result got %0d exp 4", power_out);
        else passed++;
    endtask

    task automatic test_back_to_back_random();
        int d;
        for (int i = 0; i < 600; i++) begin
            power_ready = ($urandom_range(0, 1) == 1);
            overrun_clr = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) d = int'($urandom);
            else d = int'($urandom_range(0, 40)) - 20;
            step(1'b1, ($urandom_range(0, 9) < 8), d);
            total++;
            if (obs !== exp_v) $display("FAIL random_model i=%0d got %h exp %h", i, obs, exp_v);
            else passed++;
        end
        overrun_clr = 1'b0;
        power_ready = 1'b1;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_min_sample();
        test_overrun();
        test_abort();
        test_reset_mid();
        test_back_to_back_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
